register_file_dump_controller: RTL and testbench

REGISTER_FILE_DUMP_CONTROLLER -- requirements
Module: register_file_dump_controller

---
 rtl/register_file_dump_controller_pkg.sv | 17 +
 rtl/register_file_dump_controller.sv | 81 ++++++++
 tb/tb_register_file_dump_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_dump_controller_pkg.sv
// Shared constants for the register file dump controller: default sizing
// and the dump FSM state encoding.
package register_file_dump_controller_pkg;

  localparam int unsigned DEF_CANT_REGISTROS              = 32;
  localparam int unsigned DEF_CANT_BITS_REGISTROS         = 32;
  localparam int unsigned DEF_CANT_BITS_ADDRESS_REGISTROS = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_READ      = 3'd2,
    ST_SEND      = 3'd3,
    ST_DONE      = 3'd4
  } dump_state_t;

endpackage

// File: rtl/register_file_dump_controller.sv
// Halts the pipeline, walks register file port A from index 0 to the last
// register and streams each value out over a valid/ready handshake.
module register_file_dump_controller
  import register_file_dump_controller_pkg::*;
#(
  parameter int unsigned CANT_REGISTROS              = DEF_CANT_REGISTROS,
  parameter int unsigned CANT_BITS_REGISTROS         = DEF_CANT_BITS_REGISTROS,
  parameter int unsigned CANT_BITS_ADDRESS_REGISTROS = DEF_CANT_BITS_ADDRESS_REGISTROS
) (
  input  logic                                   i_clock,
  input  logic                                   i_soft_reset,
  input  logic                                   i_start,
  input  logic                                   i_pipeline_halted,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_reg_A_pipeline,
  output logic [CANT_BITS_ADDRESS_REGISTROS-1:0] o_reg_A,
  input  logic [CANT_BITS_REGISTROS-1:0]         i_data_A,
  output logic                                   o_stall_request,
  output logic [CANT_BITS_REGISTROS-1:0]         o_data,
  output logic [CANT_BITS_ADDRESS_REGISTROS-1:0] o_reg_index,
  output logic                                   o_data_valid,
  input  logic                                   i_data_ready,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam logic [CANT_BITS_ADDRESS_REGISTROS-1:0] LAST_INDEX =
    CANT_BITS_ADDRESS_REGISTROS'(CANT_REGISTROS - 1);

  dump_state_t                            state;
  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] index;

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      o_data       <= '0;
      o_reg_index  <= '0;
      o_data_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state <= ST_WAIT_HALT;
        end
        ST_WAIT_HALT: begin
          index <= '0;
          if (i_pipeline_halted) state <= ST_READ;
        end
        ST_READ: begin
          o_data       <= i_data_A;
          o_reg_index  <= index;
          o_data_valid <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND: begin
          // Terminal index ends the walk instead of wrapping back to 0.
          if (o_data_valid && i_data_ready) begin
            o_data_valid <= 1'b0;
            if (index == LAST_INDEX) begin
              state <= ST_DONE;
            end else begin
              index <= index + 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The pipeline decoder owns port A only while idle; the dump owns it otherwise.
  always_comb begin
    o_reg_A = (state == ST_IDLE) ? i_reg_A_pipeline : index;
  end

  assign o_busy          = (state != ST_IDLE);
  assign o_stall_request = (state != ST_IDLE);
  assign o_done          = (state == ST_DONE);

endmodule

// File: tb/tb_register_file_dump_controller.sv
// Directed bench for register_file_dump_controller with a register file
// model holding 0x100+i in register i.
module tb_register_file_dump_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halted;
  logic [4:0]  pipe_addr;
  logic [4:0]  reg_a;
  logic [31:0] data_a;
  logic        stall;
  logic [31:0] data;
  logic [4:0]  reg_index;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_a = 32'h100 + {27'd0, reg_a};

  register_file_dump_controller #(
    .CANT_REGISTROS             (32),
    .CANT_BITS_REGISTROS        (32),
    .CANT_BITS_ADDRESS_REGISTROS(5)
  ) dut (
    .i_clock          (clk),
    .i_soft_reset     (rst),
    .i_start          (start),
    .i_pipeline_halted(halted),
    .i_reg_A_pipeline (pipe_addr),
    .o_reg_A          (reg_a),
    .i_data_A         (data_a),
    .o_stall_request  (stall),
    .o_data           (data),
    .o_reg_index      (reg_index),
    .o_data_valid     (valid),
    .i_data_ready     (ready),
    .o_busy           (busy),
    .o_done           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follows a dump already in progress until o_done, checking every beat.
  task automatic collect(input bit do_hold, input bit do_pulse,
                         output int beats, output int dones);
    bit held = 0;
    bit pulsed = 0;
    bit done_seen = 0;
    int tail = 0;
    beats = 0;
    dones = 0;
    for (int cyc = 0; cyc < 400 && tail < 4; cyc++) begin
      if (do_hold && valid && reg_index == 5'd7 && !held) begin
        held  = 1;
        ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          step();
          check("hold_data", data, 32'h107);
          check("hold_index", {27'd0, reg_index}, 32'd7);
          check("hold_valid", {31'd0, valid}, 32'd1);
        end
        ready = 1'b1;
      end
      if (do_pulse && valid && reg_index == 5'd3 && !pulsed) begin
        pulsed = 1;
        start  = 1'b1;
      end
      if (done) begin
        dones++;
        done_seen = 1;
      end
      if (valid) check("send_reg_a", {27'd0, reg_a}, beats);
      if (valid && ready) begin
        check("beat_index", {27'd0, reg_index}, beats);
        check("beat_data", data, 32'h100 + beats);
        beats++;
      end
      if (done_seen) tail++;
      step();
      start = 1'b0;
    end
    check("dump_finished", {31'd0, done_seen}, 32'd1);
  endtask

  initial begin
    int beats;
    int dones;
    bit found;
    bit v_exp;

    rst       = 1'b1;
    start     = 1'b0;
    halted    = 1'b1;
    ready     = 1'b1;
    pipe_addr = 5'd9;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_index", {27'd0, reg_index}, 32'd0);
    check("idle_reg_a", {27'd0, reg_a}, 32'd9);

    // Full dump with exact latency: beat k at N+3+2k, o_done at N+66.
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      step();
      start = 1'b0;
      v_exp = (c >= 3 && c <= 65 && ((c - 3) % 2 == 0));
      check("lat_valid", {31'd0, valid}, {31'd0, v_exp});
      check("lat_done", {31'd0, done}, (c == 66) ? 32'd1 : 32'd0);
      check("lat_busy", {31'd0, busy}, (c <= 66) ? 32'd1 : 32'd0);
      check("lat_stall", {31'd0, stall}, (c <= 66) ? 32'd1 : 32'd0);
      if (v_exp) begin
        check("lat_data", data, 32'h100 + (c - 3) / 2);
        check("lat_index", {27'd0, reg_index}, (c - 3) / 2);
      end
      if (c >= 2 && c <= 65) check("lat_reg_a", {27'd0, reg_a}, (c - 2) / 2);
    end
    check("idle_reg_a_after", {27'd0, reg_a}, 32'd9);
    pipe_addr = 5'd17;
    #1;
    check("idle_reg_a_comb", {27'd0, reg_a}, 32'd17);

    // Backpressure on beat 7.
    start = 1'b1;
    step();
    start = 1'b0;
    collect(1'b1, 1'b0, beats, dones);
    check("bp_beats", beats, 32'd32);
    check("bp_dones", dones, 32'd1);

    // Pipeline slow to halt.
    halted = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("halt_stall", {31'd0, stall}, 32'd1);
      check("halt_busy", {31'd0, busy}, 32'd1);
      check("halt_valid", {31'd0, valid}, 32'd0);
      step();
    end
    halted = 1'b1;
    step();
    check("halt_read_valid", {31'd0, valid}, 32'd0);
    step();
    check("halt_first_valid", {31'd0, valid}, 32'd1);
    check("halt_first_index", {27'd0, reg_index}, 32'd0);
    collect(1'b0, 1'b0, beats, dones);
    check("halt_beats", beats, 32'd32);
    check("halt_dones", dones, 32'd1);

    // Reset mid-dump at beat 12, then a clean restart.
    start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (valid && reg_index == 5'd12) found = 1;
      else step();
    end
    check("reach_beat12", {31'd0, found}, 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_index", {27'd0, reg_index}, 32'd0);
    check("mid_rst_reg_a", {27'd0, reg_a}, 32'd17);
    step();
    check("mid_rst_no_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    collect(1'b0, 1'b0, beats, dones);
    check("restart_beats", beats, 32'd32);
    check("restart_dones", dones, 32'd1);

    // Start pulse during beat 3 must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    collect(1'b0, 1'b1, beats, dones);
    check("ignore_beats", beats, 32'd32);
    check("ignore_dones", dones, 32'd1);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
